// File: rtl/pc_fetch_unit_pkg.sv
// Shared control encodings for the fetch path: FSM state codes, the default
// reset PC and the next-PC select opcodes used by the next-PC logic.
package pc_fetch_unit_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_RETRY = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  // Word address; byte address 0x0000_3000.
  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0C00;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b011;

  function automatic logic is_busy(input logic [1:0] st);
    return (st == ST_REQ) || (st == ST_RETRY);
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Program counter plus a single-outstanding instruction fetch with a per-attempt
// timeout, bounded retries and a sticky error state left only by reset.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [29:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          TIMEOUT   = 16,
  parameter int          MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] npc,
  input  logic        pc_wr,
  input  logic        fetch_start,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:2] pc,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic        fetch_err,
  output logic [1:0]  state,
  output logic [7:0]  retry_cnt
);

  // Handshake: imem_req stays high with imem_addr stable for the whole REQ
  // window; a cycle with imem_req=1 and imem_ack=1 transfers imem_rdata.
  // An ack in any other cycle carries no transfer.

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
    end else begin
      instr_valid <= 1'b0;
      if (pc_wr) pc <= npc;
      case (state)
        ST_IDLE: begin
          if (fetch_start) begin
            // Write-through: a same-cycle PC write is the address fetched.
            imem_addr <= pc_wr ? npc : pc;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack wins over a timeout expiring in the same cycle.
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMO_LAST) state <= ST_RETRY;
          end
        end
        ST_RETRY: begin
          retry_cnt <= retry_cnt + 8'd1;
          tmo_cnt   <= '0;
          state     <= (retry_cnt < 8'(MAX_RETRY)) ? ST_REQ : ST_ERR;
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req  = (state == ST_REQ);
  assign busy      = is_busy(state);
  assign fetch_err = (state == ST_ERR);

endmodule
